// File: rtl/top.sv
// Message sequencer: synchronizes a next-message button and an abort line, then steps
// through a slot index with a clear strobe, a timed enable window and a free-running divided clock.
module top #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned NUM_MSGS   = 10,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned MSG_LEN    = 16,
  parameter logic [15:0] TYPE_MASK  = 16'hAAAA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       next_msg,
  input  logic       signal,
  output logic       cclr_neg,
  output logic       clk_out,
  output logic       msg_enable,
  output logic       msg_type,
  output logic [3:0] num
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned NUM_W = 4;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [NUM_W-1:0] NUM_LAST  = NUM_W'(NUM_MSGS - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SEND_LOAD = CNT_W'(MSG_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_nm_sync;
  logic [2:0]       r_sig_sync;
  logic [1:0]       r_rel;
  logic             r_nm_arm;
  logic             r_sig_arm;
  logic             w_nm_rise;
  logic             w_sig_rise;
  logic             w_cnt_zero;
  logic [NUM_W-1:0] w_num_inc;
  logic [NUM_W-1:0] w_num_nxt;
  logic             w_type_nxt;
  logic             w_cclr_nxt;
  logic             w_en_nxt;

  // Two-flop synchronizers plus a history flop; an edge is only honoured once the
  // synchronized line has been seen low after reset, so a level held through reset is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nm_sync  <= '0;
      r_sig_sync <= '0;
      r_rel      <= '0;
      r_nm_arm   <= 1'b0;
      r_sig_arm  <= 1'b0;
    end else begin
      r_nm_sync  <= {r_nm_sync[1:0], next_msg};
      r_sig_sync <= {r_sig_sync[1:0], signal};
      r_rel      <= {r_rel[0], 1'b1};
      r_nm_arm   <= r_nm_arm  | (r_rel[1] & ~r_nm_sync[1]);
      r_sig_arm  <= r_sig_arm | (r_rel[1] & ~r_sig_sync[1]);
    end
  end

  assign w_nm_rise  = r_nm_sync[1]  & ~r_nm_sync[2]  & r_nm_arm;
  assign w_sig_rise = r_sig_sync[1] & ~r_sig_sync[2] & r_sig_arm;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_num_inc  = (num == NUM_LAST) ? '0 : num + NUM_W'(1);

  // Free-running clock divider, unaffected by the sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div   <= '0;
      clk_out <= 1'b0;
    end else if (r_div == DIV_LAST) begin
      r_div   <= '0;
      clk_out <= ~clk_out;
    end else begin
      r_div   <= r_div + DIV_W'(1);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      num        <= '0;
      msg_type   <= TYPE_MASK[0];
      cclr_neg   <= 1'b1;
      msg_enable <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      num        <= w_num_nxt;
      msg_type   <= w_type_nxt;
      cclr_neg   <= w_cclr_nxt;
      msg_enable <= w_en_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_nm_rise)                w_state_nxt = CLEAR;
      CLEAR:   if (w_cnt_zero)               w_state_nxt = SEND;
      SEND:    if (w_sig_rise || w_cnt_zero) w_state_nxt = IDLE;
      default:                               w_state_nxt = IDLE;
    endcase
  end

  // An abort edge coinciding with window expiry takes the same single exit.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_num_nxt  = num;
    w_type_nxt = msg_type;
    w_cclr_nxt = cclr_neg;
    w_en_nxt   = msg_enable;
    case (r_state)
      IDLE: begin
        if (w_nm_rise) begin
          w_num_nxt  = w_num_inc;
          w_type_nxt = TYPE_MASK[w_num_inc];
          w_cclr_nxt = 1'b0;
          w_cnt_nxt  = CLR_LOAD;
        end
      end
      CLEAR: begin
        if (w_cnt_zero) begin
          w_cclr_nxt = 1'b1;
          w_en_nxt   = 1'b1;
          w_cnt_nxt  = SEND_LOAD;
        end else begin
          w_cnt_nxt  = r_cnt - CNT_W'(1);
        end
      end
      SEND: begin
        if (w_sig_rise || w_cnt_zero) begin
          w_en_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_cclr_nxt = 1'b1;
        w_en_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_top.sv
// Directed bench for the message sequencer: reset, divider, message timing, wrap,
// abort, ignored requests and asynchronous reset.
module tb_top;

  logic       clk;
  logic       rst;
  logic       next_msg;
  logic       signal;
  logic       cclr_neg;
  logic       clk_out;
  logic       msg_enable;
  logic       msg_type;
  logic [3:0] num;

  int errors = 0;
  int checks = 0;

  top dut (
    .clk        (clk),
    .rst        (rst),
    .next_msg   (next_msg),
    .signal     (signal),
    .cclr_neg   (cclr_neg),
    .clk_out    (clk_out),
    .msg_enable (msg_enable),
    .msg_type   (msg_type),
    .num        (num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One short request pulse followed by enough idle time for a full message.
  task automatic pulse_and_finish();
    next_msg = 1'b1;
    tick(2);
    next_msg = 1'b0;
    tick(26);
  endtask

  initial begin
    rst      = 1'b0;
    next_msg = 1'b0;
    signal   = 1'b0;
    tick(2);
    chk("rst_num",    16'(num),        16'd0);
    chk("rst_type",   16'(msg_type),   16'd0);
    chk("rst_en",     16'(msg_enable), 16'd0);
    chk("rst_cclr",   16'(cclr_neg),   16'd1);
    chk("rst_clkout", 16'(clk_out),    16'd0);
    rst = 1'b1;

    // clk_out toggles every 4 posedges after release
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      chk("div_clkout", 16'(clk_out), 16'((i / 4) % 2));
    end
    chk("idle_num",  16'(num),        16'd0);
    chk("idle_en",   16'(msg_enable), 16'd0);
    chk("idle_cclr", 16'(cclr_neg),   16'd1);

    // Long press: 3-cycle latency, 2-cycle clear, 16-cycle window, single advance
    next_msg = 1'b1;
    tick(2);
    chk("lat_cclr_still_hi", 16'(cclr_neg), 16'd1);
    chk("lat_num_still_0",   16'(num),      16'd0);
    tick(1);
    chk("clr1_cclr", 16'(cclr_neg),   16'd0);
    chk("clr1_num",  16'(num),        16'd1);
    chk("clr1_type", 16'(msg_type),   16'd1);
    chk("clr1_en",   16'(msg_enable), 16'd0);
    tick(1);
    chk("clr2_cclr", 16'(cclr_neg),   16'd0);
    tick(1);
    chk("send_cclr", 16'(cclr_neg),   16'd1);
    chk("send_en",   16'(msg_enable), 16'd1);
    next_msg = 1'b0;
    tick(15);
    chk("send_last_en", 16'(msg_enable), 16'd1);
    tick(1);
    chk("send_end_en",  16'(msg_enable), 16'd0);
    tick(10);
    chk("hold_one_adv", 16'(num),        16'd1);

    // Reset back to slot 0, then ten requests: 1..9 then wrap to 0
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(5);
    chk("rst2_num", 16'(num), 16'd0);
    for (int i = 1; i <= 10; i++) begin
      pulse_and_finish();
      chk("seq_num",  16'(num),        16'(i % 10));
      chk("seq_type", 16'(msg_type),   16'((i % 10) % 2));
      chk("seq_en",   16'(msg_enable), 16'd0);
    end

    // Abort line outside SEND has no effect
    signal = 1'b1;
    tick(2);
    signal = 1'b0;
    tick(5);
    chk("sig_idle_num",  16'(num),        16'd0);
    chk("sig_idle_en",   16'(msg_enable), 16'd0);
    chk("sig_idle_cclr", 16'(cclr_neg),   16'd1);

    // Abort 5 cycles into SEND; a request during SEND is not queued
    next_msg = 1'b1;
    tick(2);
    next_msg = 1'b0;
    tick(3);
    chk("abort_send_en", 16'(msg_enable), 16'd1);
    chk("abort_num",     16'(num),        16'd1);
    next_msg = 1'b1;
    tick(2);
    next_msg = 1'b0;
    tick(3);
    signal = 1'b1;
    tick(2);
    chk("abort_en_still_hi", 16'(msg_enable), 16'd1);
    tick(1);
    chk("abort_en_drop",     16'(msg_enable), 16'd0);
    signal = 1'b0;
    tick(20);
    chk("abort_no_queue_num", 16'(num),        16'd1);
    chk("abort_no_queue_en",  16'(msg_enable), 16'd0);
    chk("abort_no_queue_cl",  16'(cclr_neg),   16'd1);

    // Asynchronous reset during SEND, with the request held across release
    next_msg = 1'b1;
    tick(2);
    next_msg = 1'b0;
    tick(6);
    chk("arst_pre_en", 16'(msg_enable), 16'd1);
    next_msg = 1'b1;
    rst = 1'b0;
    #1;
    chk("arst_en",   16'(msg_enable), 16'd0);
    chk("arst_num",  16'(num),        16'd0);
    chk("arst_cclr", 16'(cclr_neg),   16'd1);
    chk("arst_type", 16'(msg_type),   16'd0);
    chk("arst_clk",  16'(clk_out),    16'd0);
    tick(1);
    rst = 1'b1;
    tick(10);
    chk("held_level_num",  16'(num),      16'd0);
    chk("held_level_cclr", 16'(cclr_neg), 16'd1);
    next_msg = 1'b0;
    tick(4);
    pulse_and_finish();
    chk("post_rst_adv_num", 16'(num), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
